conv_seq_ctrl: RTL and testbench
================================

# conv_seq_ctrl

Control sequencer for the CONV engine: walks the 64x64 input image, issues the nine 3x3 tap addresses per pixel with zero-padding flags, and commands the MAC/ReLU datapath to write each Layer 0 result. It then runs the 2x2 max-pool pass, reading Layer 0 and writing Layer 1 (32x32). It drives the engine's `busy`/`ready` handshake and the shared `csel`/`crd`/`cwr` memory port. Arithmetic is in a separate datapath block; this block holds only counters, the FSM and the address logic.

## Interface
- MAC_LAT, 1: cycles from the last tap's `tap_vld` to the result being valid at the datapath output (range 1..3).
- clk  in  1  clock; all logic is posedge.
- reset  in  1  synchronous, active-high reset.
- ready  in  1  start request; sampled only in IDLE.
- busy  out  1  high for the whole operation.
- iaddr  out  12  image address `{row[5:0], col[5:0]}`.
- tap_vld  out  1  the datapath consumes `idata` this cycle.
- tap_idx  out  4  kernel weight index 0..8; aligned with `tap_vld`.
- tap_pad  out  1  use 0 instead of `idata`; aligned with `tap_vld`.
- acc_clr  out  1  load the accumulator rather than add; high with tap 0.
- crd  out  1  Layer 0 read strobe.
- caddr_rd  out  12  Layer 0 read address.
- pool_vld  out  1  `cdata_rd` is valid for the max compare.
- pool_first  out  1  load the max register rather than compare; high with the first pool read.
- cwr  out  1  write strobe.
- caddr_wr  out  12  write address.
- csel  out  3  memory select: 000 idle, 001 Layer 0, 011 Layer 1.
- wr_sel  out  1  `cdata_wr` mux select: 0 = conv result, 1 = pool max.

## Operation
- FSM states and transitions:
  - IDLE: leaves to CONV_TAP when `ready`=1.
  - CONV_TAP (9 cycles) -> CONV_WAIT (MAC_LAT cycles) -> CONV_WB (1 cycle).
  - CONV_WB returns to CONV_TAP for the next pixel; after pixel 4095 it goes to POOL_RD.
  - POOL_RD (4 cycles) -> POOL_WAIT (1 cycle) -> POOL_WB (1 cycle).
  - POOL_WB returns to POOL_RD for the next output; after output 1023 it goes to IDLE.
- Pixel order is raster: row 0..63, and within a row col 0..63.
- Tap k uses dy = k/3 - 1 and dx = k%3 - 1. The row/col arithmetic is 7-bit signed.
- `tap_pad` = 1 when row+dy or col+dx falls outside 0..63. For a padded tap, `iaddr` = the center pixel address.
- CONV_WB: `cwr`=1, `csel`=001, `caddr_wr`=pixel index, `wr_sel`=0.
- Pool output (y,x) reads, in order: `{2y,2x}`, `{2y,2x+1}`, `{2y+1,2x}`, `{2y+1,2x+1}`.
- POOL_WB: `cwr`=1, `csel`=011, `caddr_wr`=`{y[4:0],x[4:0]}`, `wr_sel`=1.
- `csel`=001 during CONV_* states and the POOL_RD/POOL_WAIT states; 000 in IDLE.
- Reset values: every output is 0 (`csel`=000, `busy`=0), the state is IDLE and the counters are 0.
- Reset mid-operation: the next edge returns to IDLE, all outputs go to 0, and no further writes are issued. The next `ready` restarts from pixel 0.
- A `ready` that stays high after completion starts a new run one cycle after the return to IDLE.

## Timing
- `ready` is sampled at edge E. From E+1: `busy`=1 and tap 0 `iaddr` are driven.
- `iaddr` is issued in cycle t; `tap_vld`, `tap_idx` and `tap_pad` follow in t+1, when `idata` is valid.
- Conv pixel period = 10+MAC_LAT cycles:
  - taps are issued in c0..c8;
  - `tap_vld` is high in c1..c9;
  - `cwr` is high in c(9+MAC_LAT).
- Pool period = 6 cycles:
  - `crd` is high in p0..p3;
  - `pool_vld` is high in p1..p4, with `pool_first` in p1;
  - `cwr` is high in p5.
- There is no gap between pixels, between pool outputs, or between the two phases.
- `busy` falls on the edge after the last Layer 1 write.
- `busy` is high for exactly 4096·(10+MAC_LAT) + 1024·6 cycles (51200 cycles at MAC_LAT=1).
- Outputs are registered. `cwr` and `crd` are never high in the same cycle.

## Configuration
- `CONV_SEQ_POOL_EN` defined: both phases run as described above.
- Undefined:
  - the POOL states are removed, and `crd`, `pool_vld`, `pool_first` and `wr_sel` are tied to 0;
  - after pixel 4095 the FSM goes to IDLE;
  - `busy` is high for 4096·(10+MAC_LAT) cycles (45056 at MAC_LAT=1);
  - `csel`=011 is never driven.

## Test plan
- Reset held 3 cycles with `ready`=1: all outputs are 0 and `csel`=000. After release, `busy`=1 one cycle after `ready` is sampled, and tap 0 `iaddr`=0 with pad to follow.
- Pixel 0, MAC_LAT=1:
  - `tap_pad` pattern for taps 0..8 is 1,1,1,1,0,0,1,0,0;
  - `iaddr` for taps 4/5/7/8 = 0/1/64/65;
  - `cwr` in c10 with `caddr_wr`=0 and `csel`=001.
- Pixel 4095: tap 0 `iaddr`=4030; taps 2,5,6,7,8 padded; `caddr_wr`=4095.
- Pool output 33: `caddr_rd` = 130,131,194,195; `pool_first` with the first read; `caddr_wr`=33, `csel`=011, `wr_sel`=1.
- Full run at MAC_LAT=1:
  - `busy` is high for 51200 cycles;
  - there are 4096 Layer 0 and 1024 Layer 1 writes, each address exactly once;
  - the last write goes to 1023;
  - without `CONV_SEQ_POOL_EN`: `busy` is high for 45056 cycles.
- `reset` pulsed during pixel 100:
  - the next cycle has `busy`=0 and `cwr`=0;
  - a new `ready` restarts with tap 0 `iaddr`=0, and the first `caddr_wr`=0.

Source files
------------

// File: rtl/conv_seq_ctrl.sv
// CONV engine control sequencer: 3x3 conv tap walk over a 64x64 image, then optional 2x2 max-pool pass.
// Optional pool phase enabled by defining CONV_SEQ_POOL_EN.
module conv_seq_ctrl #(
  parameter int unsigned MAC_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ready,
  output logic        busy,
  output logic [11:0] iaddr,
  output logic        tap_vld,
  output logic [3:0]  tap_idx,
  output logic        tap_pad,
  output logic        acc_clr,
  output logic        crd,
  output logic [11:0] caddr_rd,
  output logic        pool_vld,
  output logic        pool_first,
  output logic        cwr,
  output logic [11:0] caddr_wr,
  output logic [2:0]  csel,
  output logic        wr_sel
);

  typedef enum logic [2:0] {
    IDLE, CONV_TAP, CONV_WAIT, CONV_WB
`ifdef CONV_SEQ_POOL_EN
    , POOL_RD, POOL_WAIT, POOL_WB
`endif
  } state_t;

  state_t      state, state_n;
  logic [11:0] pix, pix_n;
  logic [3:0]  cnt, cnt_n;
  logic        pad_q;
`ifdef CONV_SEQ_POOL_EN
  logic [9:0]  po, po_n;
`endif

  always_comb begin
    state_n = state;
    pix_n   = pix;
    cnt_n   = cnt;
`ifdef CONV_SEQ_POOL_EN
    po_n    = po;
`endif
    case (state)
      IDLE: if (ready) begin
        state_n = CONV_TAP;
        pix_n   = '0;
        cnt_n   = '0;
      end
      CONV_TAP: if (cnt == 4'd8) begin
        state_n = CONV_WAIT;
        cnt_n   = '0;
      end else cnt_n = 4'(cnt + 4'd1);
      CONV_WAIT: if (cnt == 4'(MAC_LAT - 1)) begin
        state_n = CONV_WB;
        cnt_n   = '0;
      end else cnt_n = 4'(cnt + 4'd1);
      CONV_WB: begin
        cnt_n = '0;
        if (pix == 12'hfff) begin
`ifdef CONV_SEQ_POOL_EN
          state_n = POOL_RD;
          po_n    = '0;
`else
          state_n = IDLE;
`endif
        end else begin
          pix_n   = 12'(pix + 12'd1);
          state_n = CONV_TAP;
        end
      end
`ifdef CONV_SEQ_POOL_EN
      POOL_RD: if (cnt == 4'd3) begin
        state_n = POOL_WAIT;
        cnt_n   = '0;
      end else cnt_n = 4'(cnt + 4'd1);
      POOL_WAIT: state_n = POOL_WB;
      POOL_WB: begin
        cnt_n = '0;
        if (po == 10'h3ff) state_n = IDLE;
        else begin
          po_n    = 10'(po + 10'd1);
          state_n = POOL_RD;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  // Tap offsets in 7-bit two's complement; bit 6 of the sum flags both -1 and 64.
  logic [6:0]  dy, dx, r7, c7;
  logic        pad_n;
  logic [11:0] addr_n;

  always_comb begin
    dy = 7'd0;
    dx = 7'd0;
    case (cnt_n)
      4'd0, 4'd1, 4'd2: dy = 7'h7f;
      4'd6, 4'd7, 4'd8: dy = 7'd1;
      default:          dy = 7'd0;
    endcase
    case (cnt_n)
      4'd0, 4'd3, 4'd6: dx = 7'h7f;
      4'd2, 4'd5, 4'd8: dx = 7'd1;
      default:          dx = 7'd0;
    endcase
    r7     = 7'({1'b0, pix_n[11:6]} + dy);
    c7     = 7'({1'b0, pix_n[5:0]} + dx);
    pad_n  = r7[6] | c7[6];
    addr_n = pad_n ? pix_n : {r7[5:0], c7[5:0]};
  end

  logic        cwr_n;
  logic [11:0] waddr_n;
  logic [2:0]  csel_n;

  always_comb begin
    cwr_n   = 1'b0;
    waddr_n = '0;
    csel_n  = 3'b000;
    case (state_n)
      CONV_TAP, CONV_WAIT: csel_n = 3'b001;
      CONV_WB: begin
        cwr_n   = 1'b1;
        csel_n  = 3'b001;
        waddr_n = pix_n;
      end
`ifdef CONV_SEQ_POOL_EN
      POOL_RD, POOL_WAIT: csel_n = 3'b001;
      POOL_WB: begin
        cwr_n   = 1'b1;
        csel_n  = 3'b011;
        waddr_n = {2'b00, po_n};
      end
`endif
      default: ;
    endcase
  end

  // Outputs are registered from next-state decode so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pix      <= '0;
      cnt      <= '0;
      pad_q    <= 1'b0;
      busy     <= 1'b0;
      iaddr    <= '0;
      tap_vld  <= 1'b0;
      tap_idx  <= '0;
      tap_pad  <= 1'b0;
      acc_clr  <= 1'b0;
      cwr      <= 1'b0;
      caddr_wr <= '0;
      csel     <= 3'b000;
    end else begin
      state    <= state_n;
      pix      <= pix_n;
      cnt      <= cnt_n;
      busy     <= (state_n != IDLE);
      iaddr    <= (state_n == CONV_TAP) ? addr_n : '0;
      pad_q    <= (state_n == CONV_TAP) & pad_n;
      tap_vld  <= (state == CONV_TAP);
      tap_idx  <= (state == CONV_TAP) ? cnt : '0;
      tap_pad  <= pad_q;
      acc_clr  <= (state == CONV_TAP) && (cnt == 4'd0);
      cwr      <= cwr_n;
      caddr_wr <= waddr_n;
      csel     <= csel_n;
    end
  end

`ifdef CONV_SEQ_POOL_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      po         <= '0;
      crd        <= 1'b0;
      caddr_rd   <= '0;
      pool_vld   <= 1'b0;
      pool_first <= 1'b0;
      wr_sel     <= 1'b0;
    end else begin
      po         <= po_n;
      crd        <= (state_n == POOL_RD);
      caddr_rd   <= (state_n == POOL_RD) ? {po_n[9:5], cnt_n[1], po_n[4:0], cnt_n[0]} : '0;
      pool_vld   <= (state == POOL_RD);
      pool_first <= (state == POOL_RD) && (cnt == 4'd0);
      wr_sel     <= (state_n == POOL_WB);
    end
  end
`else
  assign crd        = 1'b0;
  assign caddr_rd   = '0;
  assign pool_vld   = 1'b0;
  assign pool_first = 1'b0;
  assign wr_sel     = 1'b0;
`endif

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Self-checking bench for conv_seq_ctrl: directed scenarios plus a full-run cycle trace
// compared against an arithmetic schedule model.
module tb_conv_seq_ctrl;
  localparam int MAC_LAT = 1;
  localparam int P  = 10 + MAC_LAT;
  localparam int NC = 4096 * P;
`ifdef CONV_SEQ_POOL_EN
  localparam int TOTAL = NC + 1024 * 6;
`else
  localparam int TOTAL = NC;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ready = 1'b1;
  logic        busy, tap_vld, tap_pad, acc_clr, crd, pool_vld, pool_first, cwr, wr_sel;
  logic [11:0] iaddr, caddr_rd, caddr_wr;
  logic [3:0]  tap_idx;
  logic [2:0]  csel;
  logic [51:0] all_out;

  int checks = 0;
  int errors = 0;

  conv_seq_ctrl #(.MAC_LAT(MAC_LAT)) dut (
    .clk(clk), .reset(reset), .ready(ready), .busy(busy), .iaddr(iaddr),
    .tap_vld(tap_vld), .tap_idx(tap_idx), .tap_pad(tap_pad), .acc_clr(acc_clr),
    .crd(crd), .caddr_rd(caddr_rd), .pool_vld(pool_vld), .pool_first(pool_first),
    .cwr(cwr), .caddr_wr(caddr_wr), .csel(csel), .wr_sel(wr_sel)
  );

  assign all_out = {busy, iaddr, tap_vld, tap_idx, tap_pad, acc_clr, crd, caddr_rd,
                    pool_vld, pool_first, cwr, caddr_wr, csel, wr_sel};

  always #5 clk = ~clk;

  // Reference tap address: neighbour of pixel p for kernel index k, clamped to centre when outside.
  function automatic void tap_ref(input int p, input int k, output int a, output bit pd);
    int r, c;
    r  = p / 64 + k / 3 - 1;
    c  = p % 64 + k % 3 - 1;
    pd = (r < 0) || (r > 63) || (c < 0) || (c > 63);
    a  = pd ? p : r * 64 + c;
  endfunction

  function automatic int pool_addr(input int o, input int q);
    return (2 * (o / 32) + q / 2) * 64 + 2 * (o % 32) + q % 2;
  endfunction

  // Leaves the bench at the first cycle after ready is sampled.
  task automatic start_run();
    @(negedge clk); ready = 1'b1;
    @(negedge clk); ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (all_out !== '0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: outputs %h, want 0", i, all_out);
      end
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || iaddr !== 12'd0) begin
      errors++;
      $display("FAIL reset_release_start: busy=%b iaddr=%0d, want busy=1 iaddr=0", busy, iaddr);
    end
    ready = 1'b0;
    @(negedge clk);
    checks++;
    if (tap_vld !== 1'b1 || tap_pad !== 1'b1 || acc_clr !== 1'b1 || tap_idx !== 4'd0) begin
      errors++;
      $display("FAIL reset_first_tap: vld=%b pad=%b clr=%b idx=%0d, want 1 1 1 0",
               tap_vld, tap_pad, acc_clr, tap_idx);
    end
    do_reset();
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL reset_pulse_clear: outputs %h, want 0", all_out);
    end
  endtask

  task automatic test_pixel0();
    logic [11:0] ia [9];
    logic [8:0]  pads;
    int          wr_cyc;
    logic [11:0] wa;
    logic [2:0]  ws;
    pads = '0; wr_cyc = -1; wa = '0; ws = '0;
    repeat ($urandom_range(1, 5)) @(negedge clk);
    start_run();
    for (int c = 0; c < P; c++) begin
      if (c <= 8) ia[c] = iaddr;
      if (c >= 1 && c <= 9) pads[c-1] = tap_pad;
      if (cwr === 1'b1 && wr_cyc < 0) begin wr_cyc = c; wa = caddr_wr; ws = csel; end
      @(negedge clk);
    end
    checks++;
    if (pads !== 9'b001001111) begin
      errors++;
      $display("FAIL pixel0_pads: got %b, want 001001111 (bit k = tap k)", pads);
    end
    checks++;
    if (ia[4] !== 12'd0 || ia[5] !== 12'd1 || ia[7] !== 12'd64 || ia[8] !== 12'd65) begin
      errors++;
      $display("FAIL pixel0_iaddr: taps4/5/7/8 = %0d/%0d/%0d/%0d, want 0/1/64/65",
               ia[4], ia[5], ia[7], ia[8]);
    end
    checks++;
    if (wr_cyc != 9 + MAC_LAT || wa !== 12'd0 || ws !== 3'b001) begin
      errors++;
      $display("FAIL pixel0_write: cycle %0d addr %0d csel %b, want cycle %0d addr 0 csel 001",
               wr_cyc, wa, ws, 9 + MAC_LAT);
    end
    do_reset();
  endtask

  task automatic test_reset_mid();
    int          off, idle_wr;
    bit          found;
    logic [11:0] wa;
    off = $urandom_range(0, P - 1);
    start_run();
    repeat (100 * P + off) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || cwr !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_stop: busy=%b cwr=%b, want 0 0", busy, cwr);
    end
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: %h, want 0", all_out);
    end
    idle_wr = 0;
    repeat ($urandom_range(2, 6)) begin
      @(negedge clk);
      if (cwr !== 1'b0 || busy !== 1'b0) idle_wr++;
    end
    checks++;
    if (idle_wr != 0) begin
      errors++;
      $display("FAIL mid_reset_idle: %0d active cycles, want 0", idle_wr);
    end
    start_run();
    checks++;
    if (iaddr !== 12'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_tap0: iaddr=%0d busy=%b, want 0 1", iaddr, busy);
    end
    found = 0; wa = '0;
    for (int i = 0; i < 2 * P && !found; i++) begin
      @(negedge clk);
      if (cwr === 1'b1) begin found = 1; wa = caddr_wr; end
    end
    checks++;
    if (!found || wa !== 12'd0) begin
      errors++;
      $display("FAIL restart_first_write: found=%0d addr=%0d, want 1 0", found, wa);
    end
    do_reset();
  endtask

  task automatic test_full_run();
    int          trace_err, busy_cyc, n0, n1, bad0, bad1, last_wr;
    int          w0 [4096];
    int          w1 [1024];
    string       first_msg, m;
    int          p, c, a;
    bit          pd, ev;
    logic [11:0] tap0_4095, wa_4095;
    logic [8:0]  pad_4095;
`ifdef CONV_SEQ_POOL_EN
    int          o, q;
    logic [11:0] rd33 [4];
    logic        pf33, ws33;
    logic [11:0] wa33;
    logic [2:0]  cs33;
`endif
    trace_err = 0; busy_cyc = 0; n0 = 0; n1 = 0; last_wr = -1; first_msg = "";
    tap0_4095 = '0; wa_4095 = '0; pad_4095 = '0;
    foreach (w0[i]) w0[i] = 0;
    foreach (w1[i]) w1[i] = 0;
    start_run();
    for (int t = 0; t < TOTAL + 3; t++) begin
      m = "";
      if (busy === 1'b1) busy_cyc++;
      if (cwr === 1'b1 && crd === 1'b1) m = $sformatf("t=%0d cwr and crd together", t);
      if (cwr === 1'b1) begin
        if (csel === 3'b001) begin n0++; w0[caddr_wr]++; end
        else if (csel === 3'b011) begin n1++; w1[caddr_wr[9:0]]++; end
        last_wr = caddr_wr;
      end
`ifndef CONV_SEQ_POOL_EN
      if (crd !== 1'b0 || pool_vld !== 1'b0 || pool_first !== 1'b0 || wr_sel !== 1'b0)
        m = $sformatf("t=%0d pool signal active without pool phase", t);
`endif
      if (t < NC) begin
        p = t / P; c = t % P;
        if (busy !== 1'b1 || csel !== 3'b001 || crd !== 1'b0)
          m = $sformatf("t=%0d conv busy=%b csel=%b crd=%b", t, busy, csel, crd);
        if (c <= 8) begin
          tap_ref(p, c, a, pd);
          if (iaddr !== 12'(a)) m = $sformatf("t=%0d pix %0d tap %0d iaddr %0d want %0d", t, p, c, iaddr, a);
          if (p == 4095 && c == 0) tap0_4095 = iaddr;
        end
        ev = (c >= 1 && c <= 9);
        if (tap_vld !== ev) m = $sformatf("t=%0d tap_vld %b want %b", t, tap_vld, ev);
        if (ev) begin
          tap_ref(p, c - 1, a, pd);
          if (tap_idx !== 4'(c - 1) || tap_pad !== pd || acc_clr !== (c == 1))
            m = $sformatf("t=%0d pix %0d idx %0d pad %b clr %b want %0d %b %b",
                          t, p, tap_idx, tap_pad, acc_clr, c - 1, pd, c == 1);
          if (p == 4095) pad_4095[c-1] = tap_pad;
        end else if (acc_clr !== 1'b0) m = $sformatf("t=%0d stray acc_clr", t);
        ev = (c == 9 + MAC_LAT);
        if (cwr !== ev) m = $sformatf("t=%0d cwr %b want %b", t, cwr, ev);
        if (ev && (caddr_wr !== 12'(p) || wr_sel !== 1'b0))
          m = $sformatf("t=%0d conv write addr %0d sel %b want %0d 0", t, caddr_wr, wr_sel, p);
        if (ev && p == 4095) wa_4095 = caddr_wr;
      end
`ifdef CONV_SEQ_POOL_EN
      else if (t < TOTAL) begin
        o = (t - NC) / 6; q = (t - NC) % 6;
        if (busy !== 1'b1 || tap_vld !== 1'b0 || acc_clr !== 1'b0)
          m = $sformatf("t=%0d pool busy=%b tap_vld=%b", t, busy, tap_vld);
        if (csel !== ((q == 5) ? 3'b011 : 3'b001)) m = $sformatf("t=%0d pool csel %b", t, csel);
        ev = (q < 4);
        if (crd !== ev) m = $sformatf("t=%0d crd %b want %b", t, crd, ev);
        if (ev && caddr_rd !== 12'(pool_addr(o, q)))
          m = $sformatf("t=%0d out %0d rd %0d want %0d", t, o, caddr_rd, pool_addr(o, q));
        if (pool_vld !== (q >= 1 && q <= 4) || pool_first !== (q == 1))
          m = $sformatf("t=%0d pool_vld %b first %b at phase %0d", t, pool_vld, pool_first, q);
        ev = (q == 5);
        if (cwr !== ev) m = $sformatf("t=%0d pool cwr %b want %b", t, cwr, ev);
        if (ev && (caddr_wr !== 12'(o) || wr_sel !== 1'b1))
          m = $sformatf("t=%0d pool write %0d sel %b want %0d 1", t, caddr_wr, wr_sel, o);
        if (o == 33) begin
          if (q < 4) rd33[q] = caddr_rd;
          if (q == 1) pf33 = pool_first;
          if (q == 5) begin wa33 = caddr_wr; cs33 = csel; ws33 = wr_sel; end
        end
      end
`endif
      else begin
        if (busy !== 1'b0 || cwr !== 1'b0 || crd !== 1'b0 || csel !== 3'b000 || tap_vld !== 1'b0)
          m = $sformatf("t=%0d not idle after run: busy=%b cwr=%b csel=%b", t, busy, cwr, csel);
      end
      if (m != "") begin
        trace_err++;
        if (first_msg == "") first_msg = m;
      end
      // ready is only sampled in IDLE; wiggle it during the run, keep it low at the end.
      ready = (t < TOTAL - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end
    ready = 1'b0;

    checks++;
    if (trace_err != 0) begin
      errors++;
      $display("FAIL full_trace: %0d bad cycles, want 0; first: %s", trace_err, first_msg);
    end
    checks++;
    if (busy_cyc != TOTAL) begin
      errors++;
      $display("FAIL busy_length: %0d cycles, want %0d", busy_cyc, TOTAL);
    end
    bad0 = 0; bad1 = 0;
    foreach (w0[i]) if (w0[i] != 1) bad0++;
    foreach (w1[i]) if (w1[i] != 0) bad1++;
    checks++;
    if (n0 != 4096 || bad0 != 0) begin
      errors++;
      $display("FAIL layer0_writes: %0d writes, %0d addrs not hit once, want 4096 0", n0, bad0);
    end
`ifdef CONV_SEQ_POOL_EN
    bad1 = 0;
    foreach (w1[i]) if (w1[i] != 1) bad1++;
    checks++;
    if (n1 != 1024 || bad1 != 0) begin
      errors++;
      $display("FAIL layer1_writes: %0d writes, %0d addrs not hit once, want 1024 0", n1, bad1);
    end
    checks++;
    if (last_wr != 1023) begin
      errors++;
      $display("FAIL last_write: %0d, want 1023", last_wr);
    end
    checks++;
    if (rd33[0] !== 12'd130 || rd33[1] !== 12'd131 || rd33[2] !== 12'd194 || rd33[3] !== 12'd195
        || pf33 !== 1'b1) begin
      errors++;
      $display("FAIL pool33_reads: %0d %0d %0d %0d first=%b, want 130 131 194 195 first=1",
               rd33[0], rd33[1], rd33[2], rd33[3], pf33);
    end
    checks++;
    if (wa33 !== 12'd33 || cs33 !== 3'b011 || ws33 !== 1'b1) begin
      errors++;
      $display("FAIL pool33_write: addr %0d csel %b sel %b, want 33 011 1", wa33, cs33, ws33);
    end
`else
    checks++;
    if (n1 != 0 || bad1 != 0) begin
      errors++;
      $display("FAIL no_layer1: %0d csel=011 writes, want 0", n1);
    end
    checks++;
    if (last_wr != 4095) begin
      errors++;
      $display("FAIL last_write: %0d, want 4095", last_wr);
    end
`endif
    checks++;
    if (tap0_4095 !== 12'd4030 || pad_4095 !== 9'b111100100 || wa_4095 !== 12'd4095) begin
      errors++;
      $display("FAIL pixel4095: tap0 %0d pads %b waddr %0d, want 4030 111100100 4095",
               tap0_4095, pad_4095, wa_4095);
    end
  endtask

  initial begin
    test_reset();
    test_pixel0();
    test_reset_mid();
    test_full_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
